byte_serializer: RTL and testbench
==================================

BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per input word (WIDTH >= 2).
REQ-002 SHALL have parameter DEPTH, default 4, input FIFO entries (power of 2, >= 2).
REQ-003 SHALL have parameter MSB_FIRST, default 1, with 1 meaning bit WIDTH-1 is sent first and 0 meaning bit 0 is sent first.
REQ-004 SHALL have port clk  input  1  single system clock, rising-edge active.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream word present on in_word.
REQ-007 SHALL have port in_word  input  WIDTH  parallel word to serialize.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a word this cycle.
REQ-009 SHALL have port bit_en  input  1  advance enable for the serial stream, where 0 holds the current bit.
REQ-010 SHALL have port data  output  1  serial bit, which feeds the downstream 1010 detector data input.
REQ-011 SHALL have port data_valid  output  1  data carries a live bit.
REQ-012 SHALL have port level  output  clog2(DEPTH)+1  FIFO occupancy, excluding the word held in the shifter.

Function
REQ-013 SHALL have in_ready = rst && (level < DEPTH), combinational, independent of a same-cycle pop.
REQ-014 SHALL write in_word to the FIFO tail at a rising edge iff in_valid && in_ready; in_valid without in_ready is ignored and nothing is stored.
REQ-015 SHALL have a two-state FSM with IDLE and SHIFT, plus a shift register of WIDTH bits and a bit counter of clog2(WIDTH) bits.
REQ-016 SHALL, in IDLE at an edge with level != 0, pop the FIFO head into the shifter, set bitcnt=WIDTH-1, go to SHIFT, and do so regardless of bit_en.
REQ-017 SHALL drive data_valid = 1 exactly when state == SHIFT, and drive data from the current shifter bit (MSB or LSB per MSB_FIRST), all registered with no combinational path from inputs.
REQ-018 SHALL, in SHIFT at an edge with bit_en=1 and bitcnt != 0, shift by one position and decrement bitcnt.
REQ-019 SHALL, in SHIFT at an edge with bit_en=1 and bitcnt == 0, pop the head into the shifter back-to-back (no idle cycle) if level != 0, else go to IDLE.
REQ-020 SHALL, in SHIFT with bit_en=0, hold the shifter, bitcnt, data and data_valid unchanged.
REQ-021 SHALL have latency from the accepting edge of a word into an empty, idle block to the first data_valid of 2 edges: the write edge, then the pop edge.
REQ-022 SHALL, on a simultaneous push and pop, leave level unchanged and keep word order strictly FIFO.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH, with level never exceeding DEPTH and never underflowing.
REQ-024 SHALL drive data = 0 in IDLE.

Reset
REQ-025 SHALL, while rst=0, asynchronously force state=IDLE, level=0, pointers=0, shifter=0, bitcnt=0, data=0, data_valid=0 and in_ready=0.
REQ-026 SHALL, on a reset asserted mid-word or mid-fill, discard the partial word and all FIFO contents with no residual output after release.
REQ-027 SHALL make in_ready rise in the first cycle after rst deasserts; the first write is possible at the next edge.

Verification
REQ-028 SHALL cover: WIDTH=8, MSB_FIRST=1, bit_en=1, push 8'hAA once -> data_valid high for exactly 8 cycles starting 2 edges after the write, data = 1,0,1,0,1,0,1,0, and the downstream detector pulses 3 times.
REQ-029 SHALL cover: push 8'hF0 then 8'h0F on consecutive cycles -> 16 contiguous data_valid cycles, bits 11110000 00001111, no gap.
REQ-030 SHALL cover: DEPTH=4, bit_en=0, push 6 words -> word 1 in the shifter, level=4, in_ready=0, word 6 dropped; then bit_en=1 -> words 1-5 are emitted in order and level returns to 0.
REQ-031 SHALL cover: bit_en pattern 1,0,0,1 during word 8'hC3 -> the second bit is held 3 cycles with data_valid=1, and the total stream is still 11000011.
REQ-032 SHALL cover: MSB_FIRST=0, push 8'h01 -> the first bit is 1 and the next 7 bits are 0.
REQ-033 SHALL cover: assert rst=0 at bit 4 of a word with 2 words queued -> data, data_valid, level and in_ready are all 0 immediately; after release, no further data_valid occurs without a new push.

Source files
------------

// File: rtl/byte_serializer.sv
// byte_serializer: FIFO-buffered parallel-to-serial converter paced by a bit-enable strobe
module byte_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_word,
  output logic                   in_ready,
  input  logic                   bit_en,
  output logic                   data,
  output logic                   data_valid,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [WIDTH-1:0] sh, sh_n;
  logic [CW-1:0] bitcnt, bitcnt_n;
  logic push, pop, empty;
  assign empty = level == '0;
  assign in_ready = rst && (level < FULL);
  assign push = in_valid && in_ready;
  assign data_valid = state == SHIFT;
  assign data = data_valid && (MSB_FIRST ? sh[WIDTH-1] : sh[0]);
  always_comb begin
    state_n = state;
    sh_n = sh;
    bitcnt_n = bitcnt;
    pop = 1'b0;
    if (state == IDLE) pop = !empty;
    else if (bit_en) begin
      if (bitcnt != '0) begin
        sh_n = MSB_FIRST ? sh << 1 : sh >> 1;
        bitcnt_n = bitcnt - 1'b1;
      end else begin
        pop = !empty;
        state_n = IDLE;
      end
    end
    if (pop) begin
      state_n = SHIFT;
      sh_n = mem[rptr];
      bitcnt_n = CW'(WIDTH-1);
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sh <= '0;
      bitcnt <= '0;
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      bitcnt <= bitcnt_n;
      wptr <= wptr + AW'(push);
      rptr <= rptr + AW'(pop);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= in_word;
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed checks of serialization order, pacing, FIFO limits and reset
module tb_byte_serializer;
  logic clk, rst, in_valid, in_valid1, bit_en;
  logic [7:0] in_word;
  logic in_ready, data, data_valid, in_ready1, data1, data_valid1;
  logic [2:0] level, level1;
  int checks = 0, errors = 0, pulses = 0;
  logic [3:0] hist;

  byte_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
    .bit_en(bit_en), .data(data), .data_valid(data_valid), .level(level));
  byte_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_word(in_word), .in_ready(in_ready1),
    .bit_en(bit_en), .data(data1), .data_valid(data_valid1), .level(level1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks eight MSB-first bits on u0, one per cycle, starting at the current negedge.
  task automatic expect_word(input logic [7:0] w, input string tag);
    for (int i = 7; i >= 0; i--) begin
      chk({tag, "_dv"}, data_valid, 1'b1);
      chk({tag, "_bit"}, data, w[i]);
      hist = {hist[2:0], data};
      if (hist == 4'b1010) pulses++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0; bit_en = 1'b1; in_word = '0; hist = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_data", data, 1'b0);
    chk("rst_level", level, 3'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1'b1);
    // single 8'hAA word, detector model counts overlapping 1010
    in_valid = 1'b1; in_word = 8'hAA;
    @(negedge clk);
    in_valid = 1'b0;
    chk("aa_dv_after_write", data_valid, 1'b0);
    chk("aa_level_after_write", level, 3'd1);
    @(negedge clk);
    expect_word(8'hAA, "aa");
    chk("aa_dv_end", data_valid, 1'b0);
    chk("aa_level_end", level, 3'd0);
    chk("aa_pulses", pulses, 3);
    // back-to-back words with no gap
    in_valid = 1'b1; in_word = 8'hF0;
    @(negedge clk);
    in_word = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    expect_word(8'hF0, "f0");
    expect_word(8'h0F, "0f");
    chk("f00f_dv_end", data_valid, 1'b0);
    chk("f00f_level_end", level, 3'd0);
    // overfill with the stream stalled: sixth word dropped
    bit_en = 1'b0; in_valid = 1'b1; in_word = 8'h11;
    @(negedge clk); in_word = 8'h22;
    @(negedge clk); in_word = 8'h33;
    @(negedge clk); in_word = 8'h44;
    @(negedge clk); in_word = 8'h55;
    @(negedge clk); in_word = 8'h66;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_level", level, 3'd4);
    chk("full_ready", in_ready, 1'b0);
    chk("full_dv_held", data_valid, 1'b1);
    @(negedge clk);
    chk("full_level_held", level, 3'd4);
    bit_en = 1'b1;
    expect_word(8'h11, "w1");
    expect_word(8'h22, "w2");
    expect_word(8'h33, "w3");
    expect_word(8'h44, "w4");
    expect_word(8'h55, "w5");
    chk("full_drop_dv", data_valid, 1'b0);
    chk("full_drop_level", level, 3'd0);
    // stall on the second bit of 8'hC3
    in_valid = 1'b1; in_word = 8'hC3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("c3_b7", data, 1'b1);
    @(negedge clk);
    bit_en = 1'b0;
    chk("c3_b6_0", data, 1'b1);
    @(negedge clk);
    chk("c3_b6_1", data, 1'b1);
    chk("c3_dv_hold1", data_valid, 1'b1);
    @(negedge clk);
    bit_en = 1'b1;
    chk("c3_b6_2", data, 1'b1);
    chk("c3_dv_hold2", data_valid, 1'b1);
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk);
      chk("c3_tail", data, (8'hC3 >> i) & 8'h1);
      chk("c3_tail_dv", data_valid, 1'b1);
    end
    @(negedge clk);
    chk("c3_dv_end", data_valid, 1'b0);
    // LSB-first instance
    in_valid1 = 1'b1; in_word = 8'h01;
    @(negedge clk);
    in_valid1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("lsb_dv", data_valid1, 1'b1);
      chk("lsb_bit", data1, i == 0);
      @(negedge clk);
    end
    chk("lsb_dv_end", data_valid1, 1'b0);
    // reset at bit 4 with two words queued
    in_valid = 1'b1; in_word = 8'hA1;
    @(negedge clk); in_word = 8'hB2;
    @(negedge clk); in_word = 8'hC3;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_bit4", data, 1'b0);
    chk("mid_level", level, 3'd2);
    chk("mid_dv", data_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst_dv", data_valid, 1'b0);
    chk("arst_data", data, 1'b0);
    chk("arst_level", level, 3'd0);
    chk("arst_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_dv", data_valid, 1'b0);
    end
    chk("post_rst_level", level, 3'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
